player_cfg_sequencer: RTL and testbench



---
 rtl/player_cfg_pkg.sv | 25 ++
 rtl/player_cfg_if.sv | 22 ++
 rtl/player_cfg_bank.sv | 63 ++++++
 rtl/player_cfg_sequencer.sv | 113 +++++++++++
 tb/tb_player_cfg_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_cfg_pkg.sv
// ---------------------------------------------------------------------------
// player_cfg_pkg
// Shared definitions for the player configuration sequencer: configuration
// word width, register address map and the sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package player_cfg_pkg;

    localparam int CFG_W   = 24;
    localparam int ADDR_W  = 4;
    localparam int DELAY_W = 5;
    localparam int STRUM_W = 4;

    // Register map: five words per group, fret order G,R,Y,B,O
    localparam logic [ADDR_W-1:0] ADDR_ON_BASE  = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_OFF_BASE = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_POS_BASE = 4'd10;
    localparam logic [ADDR_W-1:0] ADDR_MISC     = 4'd15;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/player_cfg_if.sv
// ---------------------------------------------------------------------------
// player_cfg_if
// Processor-side single-word write bus into the configuration sequencer.
//   wr_valid : write request (master -> slave)
//   wr_ready : write accepted when wr_valid && wr_ready (slave -> master)
//   wr_addr  : register select (master -> slave)
//   wr_data  : write data (master -> slave)
// ---------------------------------------------------------------------------
interface player_cfg_if #(
    parameter int CFG_W = player_cfg_pkg::CFG_W
);
    import player_cfg_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [CFG_W-1:0]  wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/player_cfg_bank.sv
// ---------------------------------------------------------------------------
// player_cfg_bank
// Register file holding one complete player configuration: 3*NUM_FRETS
// On/Off/Pos words plus delay and strum time. Used both as the shadow copy
// (written word by word) and as the live copy (loaded in parallel).
// Ports:
//   CLK, RST_N            : clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data : single-word write port (address map from pkg)
//   load_en               : parallel load of all fields from load_* inputs
//   load_words/delay/strum: parallel load data
//   words/delay/strum     : current register contents, word k at [k*CFG_W +: CFG_W]
// ---------------------------------------------------------------------------
module player_cfg_bank
    import player_cfg_pkg::*;
#(
    parameter int NUM_FRETS = 5,
    parameter int CFG_W     = player_cfg_pkg::CFG_W
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [CFG_W-1:0]               wr_data,
    input  logic                           load_en,
    input  logic [3*NUM_FRETS*CFG_W-1:0]   load_words,
    input  logic [DELAY_W-1:0]             load_delay,
    input  logic [STRUM_W-1:0]             load_strum,
    output logic [3*NUM_FRETS*CFG_W-1:0]   words,
    output logic [DELAY_W-1:0]             delay,
    output logic [STRUM_W-1:0]             strum
);

    localparam int NUM_WORDS = 3 * NUM_FRETS;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    logic [CFG_W-1:0] regs [NUM_WORDS];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_WORDS; i++) regs[i] <= '0;
            delay <= '0;
            strum <= '0;
        end else if (load_en) begin
            for (int i = 0; i < NUM_WORDS; i++) regs[i] <= load_words[i*CFG_W +: CFG_W];
            delay <= load_delay;
            strum <= load_strum;
        end else if (wr_en) begin
            // Misc word packs delay in [4:0] and strum time in [11:8]
            if (wr_addr == ADDR_MISC) begin
                delay <= wr_data[4:0];
                strum <= wr_data[11:8];
            end else if (wr_addr <= LAST_WORD) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        words = '0;
        for (int i = 0; i < NUM_WORDS; i++) words[i*CFG_W +: CFG_W] = regs[i];
    end

endmodule

// File: rtl/player_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// player_cfg_sequencer
// Collects register writes into a shadow bank and, once armed by commit_req,
// copies the whole shadow bank into the live bank on the next vsync so the
// fret controllers only ever see a complete configuration. Owns the player
// enable, which rises on the first commit and is cleared by disable_req.
// Ports:
//   CLK, RST_N       : clock, synchronous active-low reset
//   vsync            : one-cycle frame-start pulse
//   wr               : write bus (slave side); ready only while IDLE
//   commit_req       : arm a commit for the next frame boundary
//   disable_req      : clear enable_out (wins over a same-cycle commit)
//   commit_ack       : one-cycle pulse after the live bank was loaded
//   busy             : commit armed, waiting for vsync
//   on/off/pos_out   : live words, fret i at [i*CFG_W +: CFG_W]
//   delay_out        : live delay
//   strum_time_out   : live strum time
//   enable_out       : player enable
// ---------------------------------------------------------------------------
module player_cfg_sequencer
    import player_cfg_pkg::*;
#(
    parameter int NUM_FRETS = 5,
    parameter int CFG_W     = player_cfg_pkg::CFG_W
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         vsync,
    player_cfg_if.slave                  wr,
    input  logic                         commit_req,
    input  logic                         disable_req,
    output logic                         commit_ack,
    output logic                         busy,
    output logic [NUM_FRETS*CFG_W-1:0]   on_out,
    output logic [NUM_FRETS*CFG_W-1:0]   off_out,
    output logic [NUM_FRETS*CFG_W-1:0]   pos_out,
    output logic [DELAY_W-1:0]           delay_out,
    output logic [STRUM_W-1:0]           strum_time_out,
    output logic                         enable_out
);

    localparam int GRP_W   = NUM_FRETS * CFG_W;
    localparam int WORDS_W = 3 * GRP_W;

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_ARMED = ARMED;

    logic [0:0]         state;
    logic               accept;
    logic               commit;
    logic [WORDS_W-1:0] shadow_words;
    logic [DELAY_W-1:0] shadow_delay;
    logic [STRUM_W-1:0] shadow_strum;
    logic [WORDS_W-1:0] live_words;

    assign wr.wr_ready = (state == S_IDLE);
    assign busy        = (state == S_ARMED);
    assign accept      = wr.wr_valid && wr.wr_ready;
    // vsync only commits once armed; a vsync on the arming edge itself is ignored
    assign commit      = (state == S_ARMED) && vsync;

    player_cfg_bank #(.NUM_FRETS(NUM_FRETS), .CFG_W(CFG_W)) u_shadow (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wr_en      (accept),
        .wr_addr    (wr.wr_addr),
        .wr_data    (wr.wr_data),
        .load_en    (1'b0),
        .load_words ('0),
        .load_delay ('0),
        .load_strum ('0),
        .words      (shadow_words),
        .delay      (shadow_delay),
        .strum      (shadow_strum)
    );

    player_cfg_bank #(.NUM_FRETS(NUM_FRETS), .CFG_W(CFG_W)) u_live (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wr_en      (1'b0),
        .wr_addr    ('0),
        .wr_data    ('0),
        .load_en    (commit),
        .load_words (shadow_words),
        .load_delay (shadow_delay),
        .load_strum (shadow_strum),
        .words      (live_words),
        .delay      (delay_out),
        .strum      (strum_time_out)
    );

    assign on_out  = live_words[GRP_W-1:0];
    assign off_out = live_words[2*GRP_W-1:GRP_W];
    assign pos_out = live_words[3*GRP_W-1:2*GRP_W];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            commit_ack <= 1'b0;
            enable_out <= 1'b0;
        end else begin
            commit_ack <= commit;
            if (state == S_IDLE) begin
                if (commit_req) state <= S_ARMED;
            end else begin
                if (vsync) state <= S_IDLE;
            end
            if (disable_req)  enable_out <= 1'b0;
            else if (commit)  enable_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_player_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_player_cfg_sequencer
// Directed bench: stimulus pushes the expected live configuration into a
// queue when it issues a committing vsync; a monitor pops and compares it
// whenever commit_ack is seen. Directed checks cover reset, handshake and
// boundary behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_player_cfg_sequencer;
    import player_cfg_pkg::*;

    localparam int NF = 5;
    localparam int W  = 24;
    localparam int FW = NF * W;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          vsync = 1'b0;
    logic          commit_req = 1'b0;
    logic          disable_req = 1'b0;
    logic          commit_ack, busy, enable_out;
    logic [FW-1:0] on_out, off_out, pos_out;
    logic [4:0]    delay_out;
    logic [3:0]    strum_time_out;

    player_cfg_if #(.CFG_W(W)) wr_bus ();

    player_cfg_sequencer #(.NUM_FRETS(NF), .CFG_W(W)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .vsync          (vsync),
        .wr             (wr_bus),
        .commit_req     (commit_req),
        .disable_req    (disable_req),
        .commit_ack     (commit_ack),
        .busy           (busy),
        .on_out         (on_out),
        .off_out        (off_out),
        .pos_out        (pos_out),
        .delay_out      (delay_out),
        .strum_time_out (strum_time_out),
        .enable_out     (enable_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [FW-1:0] on;
        logic [FW-1:0] off;
        logic [FW-1:0] pos;
        logic [4:0]    dly;
        logic [3:0]    st;
        logic          en;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [W-1:0] sh_words [15];
    logic [4:0]  sh_dly;
    logic [3:0]  sh_st;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t snap(input logic en);
        exp_t e;
        for (int i = 0; i < NF; i++) begin
            e.on[i*W +: W]  = sh_words[i];
            e.off[i*W +: W] = sh_words[NF+i];
            e.pos[i*W +: W] = sh_words[2*NF+i];
        end
        e.dly = sh_dly;
        e.st  = sh_st;
        e.en  = en;
        return e;
    endfunction

    function automatic logic [W-1:0] dval(input int a);
        return {4'(a + 1), 4'h5, 8'(a * 3), 8'(255 - a)};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 15; i++) sh_words[i] = '0;
        sh_dly = '0;
        sh_st  = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_word(input int a, input logic [W-1:0] d);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_addr  = 4'(a);
        wr_bus.wr_data  = d;
        tick();
        wr_bus.wr_valid = 1'b0;
        if (a == 15) begin
            sh_dly = d[4:0];
            sh_st  = d[11:8];
        end else begin
            sh_words[a] = d;
        end
    endtask

    task automatic arm();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic commit_vsync(input logic en_exp);
        q.push_back(snap(en_exp));
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    // Monitor: compare live outputs against the queued expectation on every ack
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (commit_ack === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got commit_ack=1 expected no commit");
                end else begin
                    e = q.pop_front();
                    chk("mon_on",     on_out,         e.on);
                    chk("mon_off",    off_out,        e.off);
                    chk("mon_pos",    pos_out,        e.pos);
                    chk("mon_delay",  delay_out,      e.dly);
                    chk("mon_strum",  strum_time_out, e.st);
                    chk("mon_enable", enable_out,     e.en);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_addr  = '0;
        wr_bus.wr_data  = '0;
        clear_model();

        // Reset state
        tick();
        tick();
        chk("rst_on",     on_out, 0);
        chk("rst_enable", enable_out, 0);
        chk("rst_busy",   busy, 0);
        RST_N = 1'b1;
        tick();
        chk("post_rst_ready", wr_bus.wr_ready, 1);
        chk("post_rst_ack",   commit_ack, 0);

        // Basic write, arm, commit 10 cycles later
        wr_word(0, 24'hFF0000);
        chk("t1_not_live", on_out[23:0], 0);
        arm();
        chk("t1_busy",  busy, 1);
        chk("t1_ready", wr_bus.wr_ready, 0);
        for (int i = 0; i < 9; i++) tick();
        chk("t1_still_not_live", on_out[23:0], 0);
        chk("t1_enable_low",     enable_out, 0);
        commit_vsync(1'b1);
        chk("t1_on0",    on_out[23:0], 24'hFF0000);
        chk("t1_ack",    commit_ack, 1);
        chk("t1_enable", enable_out, 1);
        chk("t1_idle",   busy, 0);
        tick();
        chk("t1_ack_pulse", commit_ack, 0);

        // Write held while armed is stalled, then accepted after commit
        arm();
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_addr  = 4'd5;
        wr_bus.wr_data  = 24'h123456;
        tick();
        chk("t2_stall_ready", wr_bus.wr_ready, 0);
        commit_vsync(1'b1);
        chk("t2_ready_back", wr_bus.wr_ready, 1);
        chk("t2_off_unchanged", off_out[23:0], 0);
        tick();
        wr_bus.wr_valid = 1'b0;
        sh_words[5] = 24'h123456;
        chk("t2_off_not_live", off_out[23:0], 0);
        arm();
        commit_vsync(1'b1);
        chk("t2_off_live", off_out[23:0], 24'h123456);

        // Same-cycle write + commit_req + vsync: no commit until next vsync
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_addr  = 4'd15;
        wr_bus.wr_data  = 24'h00030A;
        commit_req = 1'b1;
        vsync = 1'b1;
        tick();
        wr_bus.wr_valid = 1'b0;
        commit_req = 1'b0;
        vsync = 1'b0;
        sh_dly = 5'd10;
        sh_st  = 4'd3;
        chk("t3_no_ack",   commit_ack, 0);
        chk("t3_busy",     busy, 1);
        chk("t3_delay_old", delay_out, 0);
        tick();
        tick();
        commit_vsync(1'b1);
        chk("t3_delay", delay_out, 10);
        chk("t3_strum", strum_time_out, 3);

        // disable_req coincident with committing vsync
        arm();
        disable_req = 1'b1;
        q.push_back(snap(1'b0));
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        disable_req = 1'b0;
        chk("t4_enable_off", enable_out, 0);
        chk("t4_ack",        commit_ack, 1);
        tick();
        // Empty commit still acks and re-enables
        arm();
        commit_vsync(1'b1);
        chk("t4_reenable", enable_out, 1);
        disable_req = 1'b1;
        tick();
        disable_req = 1'b0;
        chk("t4_idle_disable", enable_out, 0);
        chk("t4_idle_busy",    busy, 0);

        // Reset while armed with pending writes
        wr_word(1, 24'hABCDEF);
        arm();
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_addr  = 4'd2;
        wr_bus.wr_data  = 24'h777777;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        wr_bus.wr_valid = 1'b0;
        clear_model();
        chk("t5_on",     on_out, 0);
        chk("t5_off",    off_out, 0);
        chk("t5_pos",    pos_out, 0);
        chk("t5_delay",  delay_out, 0);
        chk("t5_strum",  strum_time_out, 0);
        chk("t5_enable", enable_out, 0);
        chk("t5_busy",   busy, 0);
        chk("t5_ready",  wr_bus.wr_ready, 1);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk("t5_no_ack", commit_ack, 0);
        chk("t5_on_after_vsync", on_out, 0);

        // All 16 addresses, distinct values
        for (int a = 0; a < 15; a++) wr_word(a, dval(a));
        wr_word(15, 24'hFFF51B);
        arm();
        commit_vsync(1'b1);
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("t6_on%0d", i),  on_out[i*W +: W],  dval(i));
            chk($sformatf("t6_off%0d", i), off_out[i*W +: W], dval(NF + i));
            chk($sformatf("t6_pos%0d", i), pos_out[i*W +: W], dval(2*NF + i));
        end
        chk("t6_delay",  delay_out, 5'h1B);
        chk("t6_strum",  strum_time_out, 4'h5);
        chk("t6_enable", enable_out, 1);

        tick();
        tick();
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
